// File: rtl/arbitro_roteamento.sv
// ---------------------------------------------------------------------------
// arbitro_roteamento
//
// Round-robin arbiter for two requesters (A and B) sharing one NBITS-wide
// 2:1 routing path. The winner drives the select line. The routed word is
// captured into a register with a valid strobe. Under contention, each grant
// is limited to MAX_RAJADA transfers. The grant then passes directly to the
// other side, with no idle cycle in between.
//
// Parameters
//   NBITS        width of A, B and Saida
//   MAX_RAJADA   transfers per grant while the other side requests (1..15)
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   req_a, req_b  requests from A and B
//   A, B          data words of A and B
//   gnt_a, gnt_b  grant to A / B (decoded from state)
//   sel           path select (1 = B)
//   Saida         registered routed word
//   saida_valida  Saida was written on the last edge
// ---------------------------------------------------------------------------
module arbitro_roteamento #(
    parameter int NBITS      = 4,
    parameter int MAX_RAJADA = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [NBITS-1:0] A,
    input  logic [NBITS-1:0] B,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [NBITS-1:0] Saida,
    output logic             saida_valida
);

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] GRANT_A = 2'd1;
    localparam logic [1:0] GRANT_B = 2'd2;

    // Last counter value of a burst.
    localparam logic [3:0] LIMITE = 4'(MAX_RAJADA - 1);

    logic [1:0]       r_estado;
    logic             r_ultimo;   // last side granted: 0 = A, 1 = B
    logic [3:0]       r_cont;
    logic [NBITS-1:0] r_saida;
    logic             r_valida;

    logic [1:0]       w_prox;
    logic             w_transf;
    logic             w_entra;

    assign w_transf = ((r_estado == GRANT_A) && req_a) ||
                      ((r_estado == GRANT_B) && req_b);

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO: begin
                // On a tie, the side that did not hold the last grant wins.
                if (req_a && req_b)
                    w_prox = r_ultimo ? GRANT_A : GRANT_B;
                else if (req_a)
                    w_prox = GRANT_A;
                else if (req_b)
                    w_prox = GRANT_B;
            end
            GRANT_A: begin
                if (!req_a)
                    w_prox = req_b ? GRANT_B : OCIOSO;
                else if ((r_cont == LIMITE) && req_b)
                    w_prox = GRANT_B;
            end
            GRANT_B: begin
                if (!req_b)
                    w_prox = req_a ? GRANT_A : OCIOSO;
                else if ((r_cont == LIMITE) && req_a)
                    w_prox = GRANT_A;
            end
            default: w_prox = OCIOSO;
        endcase
    end

    // A new grant starts whenever the next state is a grant state other than
    // the current one. This covers idle->grant and the direct A<->B handoff.
    assign w_entra = (w_prox != r_estado) && (w_prox != OCIOSO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
            r_ultimo <= 1'b1;
            r_cont   <= 4'd0;
            r_saida  <= '0;
            r_valida <= 1'b0;
        end else begin
            r_estado <= w_prox;
            r_valida <= w_transf;
            if (w_transf)
                r_saida <= (r_estado == GRANT_B) ? B : A;
            if (w_entra) begin
                r_cont   <= 4'd0;
                r_ultimo <= (w_prox == GRANT_B);
            end else if (w_transf) begin
                // Wraps when the burst limit is hit with no competitor.
                r_cont <= (r_cont == LIMITE) ? 4'd0 : r_cont + 4'd1;
            end
        end
    end

    assign gnt_a        = (r_estado == GRANT_A);
    assign gnt_b        = (r_estado == GRANT_B);
    assign sel          = (r_estado == GRANT_B);
    assign Saida        = r_saida;
    assign saida_valida = r_valida;

endmodule

// File: tb/tb_arbitro_roteamento.sv
module tb_arbitro_roteamento;

    localparam int NBITS = 4;
    localparam int MAXR  = 4;

    logic             clk = 1'b0;
    logic             rst_n, req_a, req_b;
    logic [NBITS-1:0] A, B;
    logic             gnt_a, gnt_b, sel, saida_valida;
    logic [NBITS-1:0] Saida;

    int errors = 0;
    int checks = 0;

    // Reference model: owner 0 = nobody, 1 = A, 2 = B.
    int               m_own;
    int               m_done;    // transfers completed in the current grant
    int               m_last;    // 1 = A, 2 = B
    logic [NBITS-1:0] m_saida;
    logic             m_vld;

    // Word the DUT should route if it transfers on the coming edge.
    logic [NBITS-1:0] exp_word;
    logic             exp_word_ok;

    arbitro_roteamento #(.NBITS(NBITS), .MAX_RAJADA(MAXR)) dut (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .A(A), .B(B), .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
        .Saida(Saida), .saida_valida(saida_valida)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model one edge using the inputs about to be sampled.
    task automatic model_step();
        int  nxt, oth;
        bit  mine, other;
        if (!rst_n) begin
            m_own = 0; m_done = 0; m_last = 2; m_saida = '0; m_vld = 1'b0;
            return;
        end
        if (m_own == 0) begin
            if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
            else if (req_a)     nxt = 1;
            else if (req_b)     nxt = 2;
            else                nxt = 0;
            m_vld = 1'b0;
        end else begin
            mine  = (m_own == 1) ? req_a : req_b;
            other = (m_own == 1) ? req_b : req_a;
            oth   = 3 - m_own;
            if (!mine) begin
                m_vld = 1'b0;
                nxt   = other ? oth : 0;
            end else begin
                m_vld   = 1'b1;
                m_saida = (m_own == 1) ? A : B;
                m_done++;
                nxt = m_own;
                if (m_done == MAXR) begin
                    if (other) nxt = oth;
                    else       m_done = 0;
                end
            end
        end
        if (nxt != m_own && nxt != 0) begin
            m_done = 0;
            m_last = nxt;
        end
        m_own = nxt;
    endtask

    task automatic compare_all();
        chk("gnt_a", int'(gnt_a), int'(m_own == 1));
        chk("gnt_b", int'(gnt_b), int'(m_own == 2));
        chk("sel", int'(sel), int'(m_own == 2));
        chk("saida_valida", int'(saida_valida), int'(m_vld));
        chk("Saida", int'(Saida), int'(m_saida));
        chk("mutex", int'(gnt_a && gnt_b), 0);
        chk("sel_eq_gnt_b", int'(sel), int'(gnt_b));
        if (saida_valida && exp_word_ok)
            chk("word_from_grant", int'(Saida), int'(exp_word));
    endtask

    // Drive inputs, step the model, and compare after the edge.
    task automatic tick(input logic rn, input logic ra, input logic rb,
                        input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
        rst_n = rn; req_a = ra; req_b = rb; A = a; B = b;
        exp_word_ok = rn && ((gnt_a === 1'b1) || (gnt_b === 1'b1));
        exp_word    = (gnt_b === 1'b1) ? b : a;
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [NBITS-1:0] seq [9];
        seq = '{4'h3, 4'h3, 4'h3, 4'h3, 4'hA, 4'hA, 4'hA, 4'hA, 4'h3};
        m_own = 0; m_done = 0; m_last = 2; m_saida = '0; m_vld = 1'b0;
        exp_word = '0; exp_word_ok = 1'b0;

        // Reset with both requesting
        tick(1'b0, 1'b1, 1'b1, 4'h3, 4'hA);
        tick(1'b0, 1'b1, 1'b1, 4'h3, 4'hA);
        chk("rst_gnt_a", int'(gnt_a), 0);
        chk("rst_gnt_b", int'(gnt_b), 0);
        chk("rst_saida", int'(Saida), 0);
        chk("rst_valida", int'(saida_valida), 0);

        // Contention: A wins first tie, then 4/4 alternation
        tick(1'b1, 1'b1, 1'b1, 4'h3, 4'hA);
        chk("first_tie_gnt_a", int'(gnt_a), 1);
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 1'b1, 1'b1, 4'h3, 4'hA);
            chk("contention_word", int'(Saida), int'(seq[i]));
            chk("contention_valid", int'(saida_valida), 1);
        end

        // Single requester B with burst wrap
        tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(1'b1, 1'b0, 1'b1, 4'h0, 4'hC);
        chk("single_gnt_b", int'(gnt_b), 1);
        chk("single_sel", int'(sel), 1);
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b0, 1'b1, 4'h0, 4'hC);
            chk("single_word", int'(Saida), 12);
            chk("single_hold", int'(gnt_b), 1);
        end

        // Early release of A after 2 transfers
        tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(1'b1, 1'b1, 1'b1, 4'h5, 4'h9);
        tick(1'b1, 1'b1, 1'b1, 4'h5, 4'h9);
        tick(1'b1, 1'b1, 1'b1, 4'h5, 4'h9);
        tick(1'b1, 1'b0, 1'b1, 4'h5, 4'h9);
        chk("early_bubble", int'(saida_valida), 0);
        chk("early_gnt_b", int'(gnt_b), 1);
        tick(1'b1, 1'b0, 1'b1, 4'h5, 4'h9);
        chk("early_b_word", int'(Saida), 9);
        tick(1'b1, 1'b0, 1'b0, 4'h5, 4'h9);
        tick(1'b1, 1'b1, 1'b1, 4'h5, 4'h9);
        chk("early_next_tie_a", int'(gnt_a), 1);

        // Reset in the middle of a burst
        tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(1'b1, 1'b1, 1'b1, 4'h6, 4'hE);
        tick(1'b1, 1'b1, 1'b1, 4'h6, 4'hE);
        tick(1'b1, 1'b1, 1'b1, 4'h6, 4'hE);
        tick(1'b0, 1'b1, 1'b1, 4'h6, 4'hE);
        chk("midrst_valid", int'(saida_valida), 0);
        chk("midrst_saida", int'(Saida), 0);
        chk("midrst_idle", int'(gnt_a | gnt_b), 0);
        tick(1'b1, 1'b1, 1'b1, 4'h6, 4'hE);
        chk("midrst_regrant_a", int'(gnt_a), 1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 1'b1, 4'h6, 4'hE);
            chk("midrst_still_a", int'(gnt_a), 1);
        end
        tick(1'b1, 1'b1, 1'b1, 4'h6, 4'hE);
        chk("midrst_full_burst_then_b", int'(gnt_b), 1);

        // Random traffic
        for (int i = 0; i < 1000; i++) begin
            tick(($urandom_range(0, 49) != 0),
                 1'($urandom), 1'($urandom),
                 NBITS'($urandom), NBITS'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbitro_roteamento.md
# arbitro_roteamento

Two-requester round-robin arbiter that shares one NBITS-wide 2:1 routing path (select 0 = A, select 1 = B) between requesters A and B. It grants the path to one requester at a time and drives the select line. It captures the selected word into a registered output with a valid strobe. Under contention it limits each grant to MAX_RAJADA transfers so neither side starves.

## Interface
- NBITS, 4, width of each data input and of Saida
- MAX_RAJADA, 4, max transfers per grant while the other side is requesting; legal range 1..15
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_a  in  1  requester A wants the path; held high until done
- req_b  in  1  requester B wants the path
- A  in  NBITS  data of requester A; stable whenever gnt_a && req_a
- B  in  NBITS  data of requester B; stable whenever gnt_b && req_b
- gnt_a  out  1  A owns the path (Moore, from state)
- gnt_b  out  1  B owns the path (Moore, from state)
- sel  out  1  path select: 1 in GRANT_B, 0 otherwise
- Saida  out  NBITS  registered routed word
- saida_valida  out  1  Saida was written on the last edge

## Operation
- State: OCIOSO, GRANT_A, GRANT_B.
- `ultimo`: 1 bit, the last side granted.
- `cont`: transfer counter, 4 bits.
- Outputs by state:
  - gnt_a = (state == GRANT_A); gnt_b = (state == GRANT_B); never both high.
  - sel = (state == GRANT_B).
- Transfer: an edge where (GRANT_A && req_a) or (GRANT_B && req_b).
  - On a transfer: Saida <= sel ? B : A; saida_valida <= 1; cont increments.
  - Otherwise: Saida holds; saida_valida <= 0.
- OCIOSO:
  - Only req_a high: go to GRANT_A.
  - Only req_b high: go to GRANT_B.
  - Both high: grant the side != ultimo.
  - Neither high: stay in OCIOSO.
- Any entry into GRANT_x: cont <= 0; ultimo <= x.
- GRANT_A (GRANT_B symmetric with roles swapped):
  - req_a low: no transfer. Next state is GRANT_B if req_b, else OCIOSO.
  - Transfer with cont == MAX_RAJADA-1 and req_b high: next state GRANT_B. A therefore gets exactly MAX_RAJADA transfers under contention.
  - Transfer with cont == MAX_RAJADA-1 and req_b low: cont wraps to 0; stay in GRANT_A.
  - Otherwise: stay in GRANT_A.
- Direct handoff GRANT_A -> GRANT_B has no OCIOSO bubble.
- Reset (rst_n low at an edge, any state, any req values):
  - state OCIOSO, cont 0, ultimo = B, so A wins the first tie.
  - Saida 0, saida_valida 0.
  - gnt_a, gnt_b, sel all 0 from the next cycle.
- Reset mid-burst discards the burst; no transfer occurs on the reset edge.
- Arithmetic: cont unsigned, never exceeds MAX_RAJADA-1 after an update. No data arithmetic; Saida is a pure copy of A or B.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from req_x to gnt_x.
- Request to grant:
  - req_x first seen high at edge t (state OCIOSO): gnt_x high during cycle t..t+1.
  - First transfer at edge t+1.
  - Saida and saida_valida reflect it during t+1..t+2.
- Latency from gnt to data: one edge.
- Throughput: one word per cycle while granted and requesting.
- Handoff under contention: the last A transfer and the first B grant occur at the same edge. The next edge is B's first transfer, so saida_valida stays continuous across the switch.
- Dropped request: one idle edge (saida_valida 0) while the grant is released.
- Requester protocol:
  - The requester must keep req_x and its data stable until it has seen gnt_x.
  - Lowering req_x while granted ends its grant at the next edge.

## Test plan
- Reset: rst_n=0 for 2 edges with req_a=req_b=1 -> gnt_a=gnt_b=sel=0, Saida=0, saida_valida=0. Release rst_n -> gnt_a=1 at edge+1, since A wins the first tie.
- Single requester: req_b=1 held, B=4'hC, req_a=0 -> gnt_b and sel=1 one edge later. Then Saida=4'hC with saida_valida=1 every cycle; cont wraps at 4 and there is no grant change.
- Contention, MAX_RAJADA=4: req_a=req_b=1, A=4'h3, B=4'hA -> Saida sequence 3,3,3,3,A,A,A,A,3,... with saida_valida continuously 1 after the first word; gnt_a and gnt_b alternate every 4 cycles.
- Early release: during GRANT_A, req_a drops after 2 transfers while req_b=1 -> one cycle with saida_valida=0, then GRANT_B; ultimo=B, so on the next tie A wins.
- Reset mid-burst: rst_n=0 at the 3rd transfer of A -> that edge produces no transfer, Saida=0, state OCIOSO. Release with both requesting -> A granted with cont restarted at 0.
- Mutual exclusion and sel: random req_a/req_b for 1000 cycles, then assert:
  - never gnt_a && gnt_b;
  - sel == gnt_b;
  - every saida_valida word equals the granted input from the previous cycle.
